dcache_mem_responder: RTL and testbench
=======================================

Name: dcache_mem_responder

Overview:
- Memory-side responder for the data-cache line-refill/writeback handshake (dcache2mem req/wr, mem2dcache ack).
- Accepts one full-line read or write request from the cache, models a fixed access latency over internal line storage, and returns a single-cycle ack with read data.
- Sits between the cache bus port and backing line storage; replaces a zero-latency memory model in cache-subsystem simulation.

Parameters:
- LINE_SIZE, 256, line width in bits (data bus width).
- BUS_ADDR_BITS, 16, byte address width on the cache-to-memory bus.
- OFFSET_BITS, 5, byte-offset bits within a line; ignored for line indexing.
- LATENCY, 3, cycles from request acceptance to ack; legal range 1..255.
- DEPTH, 2**(BUS_ADDR_BITS-OFFSET_BITS), number of lines stored.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- dcache2mem_req_i  input  1  cache request; held high until ack seen.
- dcache2mem_wr_i  input  1  1 = line write, 0 = line read; valid while req high.
- dcache2mem_addr_i  input  BUS_ADDR_BITS  byte address; line index = addr[BUS_ADDR_BITS-1:OFFSET_BITS].
- dcache2mem_wdata_i  input  LINE_SIZE  write line data.
- mem2dcache_data_o  output  LINE_SIZE  read line data, valid in the ack cycle.
- mem2dcache_ack_o  output  1  single-cycle completion pulse.
- mem_busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset low, async): state=IDLE, ack=0, data_o=0, busy=0, latency counter=0. Storage contents are not cleared.
- FSM states: IDLE, BUSY, ACK, RELEASE.
- IDLE: on req=1, latch wr, line index and wdata; load counter=LATENCY-1.
  - If LATENCY==1, go directly to ACK. Otherwise go to BUSY.
- BUSY: decrement counter each cycle. When counter==1, go to ACK.
- Request acceptance to ack-high is exactly LATENCY cycles.
- Entry to ACK (the same edge that sets ack=1):
  - Write: storage[idx] <= latched wdata; data_o unchanged.
  - Read: data_o <= storage[idx].
- ACK: ack=1 for exactly one cycle. Next state RELEASE.
- RELEASE: wait until req=0, then go to IDLE. This is a return-to-zero rule: a req held high after ack is never taken as a new request.
- Request inputs changing while in BUSY/ACK are ignored; the latched values are used.
- Read-after-write to the same line returns the newly written data. No bypass is needed because transactions are serialized.
- Reset asserted mid-transaction aborts it. A write commits only if the ACK-entry edge occurred before reset.
- Address wrap: index bits above log2(DEPTH) are discarded (modulo DEPTH).

Optional Feature:
- Macro: DCACHE_MEM_PERF_CNT_EN.
- Defined: adds outputs rd_count_o[31:0] and wr_count_o[31:0].
  - Each increments on its ack cycle and saturates at 0xFFFFFFFF.
  - Both clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dcache_mem_pkg:
  - resp_state_e enum (IDLE, BUSY, ACK, RELEASE).
  - Default constants LINE_SIZE, BUS_ADDR_BITS, OFFSET_BITS.
  - Function line_idx(addr).
- One sub-module, dcache_line_store: synchronous-write, registered-read line array (DEPTH x LINE_SIZE) with no reset. It keeps storage separate from the handshake FSM.

Test Plan:
- Reset: hold reset=0 for 2 cycles → ack=0, busy=0, data_o=0; release → state IDLE.
- Write then read, LATENCY=3:
  - Write 0xA5..A5 to addr 0x0040 with req held → ack high exactly 3 cycles after acceptance, for 1 cycle.
  - Read 0x0040 → data_o=0xA5..A5 in the ack cycle.
- Offset/wrap:
  - Write 0x1234 to addr 0x005F, read addr 0x0040 → returns 0x1234 (same line).
  - With DEPTH=16 and OFFSET_BITS=5, addr 0x0200 aliases index 0.
- Return-to-zero: keep req=1 for 4 cycles after ack → no second ack; drop req 1 cycle, then raise → new transaction, ack after LATENCY.
- Reset mid-write: write 0xFF..FF to 0x0080 (old content 0x0), assert reset in BUSY cycle 1 → no ack; subsequent read 0x0080 returns 0x0.
- LATENCY=1 and perf counters: with DCACHE_MEM_PERF_CNT_EN, run 2 reads + 1 write → ack is 1 cycle after each acceptance; rd_count_o=2, wr_count_o=1.

Source files
------------

// File: rtl/dcache_mem_pkg.sv
// dcache_mem_pkg: shared state encoding, default geometry and line-index helper for the dcache memory responder
package dcache_mem_pkg;
  localparam int LINE_SIZE = 256;
  localparam int BUS_ADDR_BITS = 16;
  localparam int OFFSET_BITS = 5;
  typedef enum logic [1:0] {IDLE, BUSY, ACK, RELEASE} resp_state_e;
  function automatic logic [31:0] line_idx(input logic [31:0] addr, input int unsigned off = OFFSET_BITS);
    return addr >> off;
  endfunction
endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: DEPTH x LINE_SIZE line array, synchronous write, registered read on re, no reset
// Ports: clk; we/re write/read strobes; addr line index; wdata write line; rdata line captured on the last re.
module dcache_line_store #(
  parameter int LINE_SIZE = 256,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [LINE_SIZE-1:0]     wdata,
  output logic [LINE_SIZE-1:0]     rdata
);
  logic [LINE_SIZE-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: fixed-latency line memory answering dcache2mem req/wr with a one-cycle mem2dcache ack
// Ports: clk; reset (async, active low); dcache2mem_* request, direction, byte address, write line;
// mem2dcache_data_o read line valid in the ack cycle; mem2dcache_ack_o completion pulse; mem_busy_o not idle.
// DCACHE_MEM_PERF_CNT_EN adds saturating rd_count_o / wr_count_o completion counters.
module dcache_mem_responder #(
  parameter int LINE_SIZE = dcache_mem_pkg::LINE_SIZE,
  parameter int BUS_ADDR_BITS = dcache_mem_pkg::BUS_ADDR_BITS,
  parameter int OFFSET_BITS = dcache_mem_pkg::OFFSET_BITS,
  parameter int LATENCY = 3,
  parameter int DEPTH = 2 ** (BUS_ADDR_BITS - OFFSET_BITS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dcache2mem_req_i,
  input  logic                     dcache2mem_wr_i,
  input  logic [BUS_ADDR_BITS-1:0] dcache2mem_addr_i,
  input  logic [LINE_SIZE-1:0]     dcache2mem_wdata_i,
  output logic [LINE_SIZE-1:0]     mem2dcache_data_o,
  output logic                     mem2dcache_ack_o,
  output logic                     mem_busy_o
`ifdef DCACHE_MEM_PERF_CNT_EN
  ,
  output logic [31:0]              rd_count_o,
  output logic [31:0]              wr_count_o
`endif
);
  import dcache_mem_pkg::*;
  localparam int IDX_W = $clog2(DEPTH);
  resp_state_e state;
  logic [7:0] cnt;
  logic wr_q, wr_eff, enter_ack, rd_valid;
  logic [IDX_W-1:0] idx_q, idx_in, idx_eff;
  logic [LINE_SIZE-1:0] wdata_q, wdata_eff, rdata;
  // Index bits above IDX_W are dropped, so addresses wrap modulo DEPTH.
  assign idx_in = IDX_W'(line_idx(32'(dcache2mem_addr_i), OFFSET_BITS));
  // With LATENCY==1 the ack-entry edge is the acceptance edge, so the live request is used there.
  assign wr_eff = state == IDLE ? dcache2mem_wr_i : wr_q;
  assign idx_eff = state == IDLE ? idx_in : idx_q;
  assign wdata_eff = state == IDLE ? dcache2mem_wdata_i : wdata_q;
  assign enter_ack = (state == IDLE && dcache2mem_req_i && LATENCY == 1) || (state == BUSY && cnt == 8'd1);
  // Store rdata has no reset; rd_valid masks it to zero until the first read after reset.
  assign mem2dcache_data_o = rd_valid ? rdata : '0;
  assign mem_busy_o = state != IDLE;
  dcache_line_store #(.LINE_SIZE(LINE_SIZE), .DEPTH(DEPTH)) u_store (
    .clk(clk),
    .we(enter_ack & wr_eff),
    .re(enter_ack & ~wr_eff),
    .addr(idx_eff),
    .wdata(wdata_eff),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      rd_valid <= 1'b0;
      mem2dcache_ack_o <= 1'b0;
`ifdef DCACHE_MEM_PERF_CNT_EN
      rd_count_o <= '0;
      wr_count_o <= '0;
`endif
    end else begin
      mem2dcache_ack_o <= enter_ack;
      if (enter_ack && !wr_eff) rd_valid <= 1'b1;
      case (state)
        IDLE: if (dcache2mem_req_i) begin
          wr_q <= dcache2mem_wr_i;
          idx_q <= idx_in;
          wdata_q <= dcache2mem_wdata_i;
          cnt <= 8'(LATENCY - 1);
          state <= LATENCY == 1 ? ACK : BUSY;
        end
        BUSY: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= ACK;
        end
        ACK: state <= RELEASE;
        default: if (!dcache2mem_req_i) state <= IDLE;
      endcase
`ifdef DCACHE_MEM_PERF_CNT_EN
      if (enter_ack && wr_eff && wr_count_o != '1) wr_count_o <= wr_count_o + 32'd1;
      if (enter_ack && !wr_eff && rd_count_o != '1) rd_count_o <= rd_count_o + 32'd1;
`endif
    end
  end
endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb_dcache_mem_responder: directed checks of a LATENCY=3 and a LATENCY=1 responder, both with DEPTH=16
module tb_dcache_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m_req = 1'b0, m_wr = 1'b0, f_req = 1'b0, f_wr = 1'b0;
  logic [15:0] m_addr = '0, f_addr = '0;
  logic [255:0] m_wdata = '0, f_wdata = '0, m_data, f_data;
  logic m_ack, m_busy, f_ack, f_busy;
  int vectors = 0;
  int errors = 0;
`ifdef DCACHE_MEM_PERF_CNT_EN
  logic [31:0] m_rd_cnt, m_wr_cnt, f_rd_cnt, f_wr_cnt;
`endif
  always #5 clk = ~clk;
  dcache_mem_responder #(.LATENCY(3), .DEPTH(16)) u_dut (
    .clk(clk), .reset(reset),
    .dcache2mem_req_i(m_req), .dcache2mem_wr_i(m_wr), .dcache2mem_addr_i(m_addr), .dcache2mem_wdata_i(m_wdata),
    .mem2dcache_data_o(m_data), .mem2dcache_ack_o(m_ack), .mem_busy_o(m_busy)
`ifdef DCACHE_MEM_PERF_CNT_EN
    , .rd_count_o(m_rd_cnt), .wr_count_o(m_wr_cnt)
`endif
  );
  dcache_mem_responder #(.LATENCY(1), .DEPTH(16)) u_fast (
    .clk(clk), .reset(reset),
    .dcache2mem_req_i(f_req), .dcache2mem_wr_i(f_wr), .dcache2mem_addr_i(f_addr), .dcache2mem_wdata_i(f_wdata),
    .mem2dcache_data_o(f_data), .mem2dcache_ack_o(f_ack), .mem_busy_o(f_busy)
`ifdef DCACHE_MEM_PERF_CNT_EN
    , .rd_count_o(f_rd_cnt), .wr_count_o(f_wr_cnt)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic txn(input bit f, input string tag, input bit w, input logic [15:0] a,
                     input logic [255:0] d, input logic [255:0] exp_rd, input bit scr);
    logic [255:0] pre;
    int n;
    pre = f ? f_data : m_data;
    if (f) begin f_req = 1'b1; f_wr = w; f_addr = a; f_wdata = d; end
    else begin m_req = 1'b1; m_wr = w; m_addr = a; m_wdata = d; end
    n = 0;
    while (!(f ? f_ack : m_ack) && n < 20) begin
      tick;
      n++;
      if (scr && n == 1) begin m_wr = ~w; m_addr = a ^ 16'h0100; m_wdata = ~d; end
    end
    chk({tag, " latency"}, 256'(n), f ? 256'd1 : 256'd3);
    chk({tag, " data"}, f ? f_data : m_data, w ? pre : exp_rd);
    tick;
    chk({tag, " pulse"}, 256'(f ? f_ack : m_ack), 256'd0);
    if (f) f_req = 1'b0; else m_req = 1'b0;
    tick;
    chk({tag, " idle"}, 256'(f ? f_busy : m_busy), 256'd0);
  endtask
  initial begin
    int n;
    tick;
    tick;
    chk("reset ack", 256'(m_ack), 256'd0);
    chk("reset busy", 256'(m_busy), 256'd0);
    chk("reset data", m_data, 256'd0);
    chk("reset fast ack", 256'(f_ack), 256'd0);
    chk("reset fast data", f_data, 256'd0);
    reset = 1'b1;
    tick;
    chk("post-reset busy", 256'(m_busy), 256'd0);
    txn(1'b0, "wr 0040", 1'b1, 16'h0040, {32{8'hA5}}, '0, 1'b0);
    txn(1'b0, "rd 0040", 1'b0, 16'h0040, '0, {32{8'hA5}}, 1'b0);
    txn(1'b0, "wr 005f", 1'b1, 16'h005F, 256'h1234, '0, 1'b1);
    txn(1'b0, "rd 0040 same line", 1'b0, 16'h0040, '0, 256'h1234, 1'b0);
    txn(1'b0, "wr 0200", 1'b1, 16'h0200, 256'hC0FFEE, '0, 1'b0);
    txn(1'b0, "rd 0000 alias", 1'b0, 16'h0000, '0, 256'hC0FFEE, 1'b0);
    m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h0040;
    n = 0;
    while (!m_ack && n < 20) begin tick; n++; end
    chk("rtz first latency", 256'(n), 256'd3);
    chk("rtz first data", m_data, 256'h1234);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rtz held ack", 256'(m_ack), 256'd0);
      chk("rtz held busy", 256'(m_busy), 256'd1);
    end
    m_req = 1'b0;
    tick;
    chk("rtz dropped busy", 256'(m_busy), 256'd0);
    m_req = 1'b1;
    n = 0;
    while (!m_ack && n < 20) begin tick; n++; end
    chk("rtz second latency", 256'(n), 256'd3);
    chk("rtz second data", m_data, 256'h1234);
    tick;
    m_req = 1'b0;
    tick;
    txn(1'b0, "wr 0080 zero", 1'b1, 16'h0080, '0, '0, 1'b0);
    m_req = 1'b1; m_wr = 1'b1; m_addr = 16'h0080; m_wdata = '1;
    tick;
    chk("abort accepted busy", 256'(m_busy), 256'd1);
    reset = 1'b0;
    #1;
    chk("abort busy", 256'(m_busy), 256'd0);
    chk("abort data", m_data, 256'd0);
    tick;
    chk("abort ack in reset", 256'(m_ack), 256'd0);
    m_req = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort no ack", 256'(m_ack), 256'd0);
    end
    txn(1'b0, "rd 0080 after abort", 1'b0, 16'h0080, '0, '0, 1'b0);
`ifdef DCACHE_MEM_PERF_CNT_EN
    chk("main rd_count", 256'(m_rd_cnt), 256'd1);
    chk("main wr_count", 256'(m_wr_cnt), 256'd0);
`endif
    txn(1'b1, "fast wr 0060", 1'b1, 16'h0060, {8{32'h0BAD_F00D}}, '0, 1'b0);
    txn(1'b1, "fast rd 0060 a", 1'b0, 16'h0060, '0, {8{32'h0BAD_F00D}}, 1'b0);
    txn(1'b1, "fast rd 0060 b", 1'b0, 16'h0060, '0, {8{32'h0BAD_F00D}}, 1'b0);
`ifdef DCACHE_MEM_PERF_CNT_EN
    chk("fast rd_count", 256'(f_rd_cnt), 256'd2);
    chk("fast wr_count", 256'(f_wr_cnt), 256'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
